// File: rtl/uart_tx.sv
// uart_tx -- 8N1 serial transmitter with a small byte FIFO in front of it.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (frame becomes 11 bit periods).
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD_RATE   serial bit rate; bit period DIV = CLK_FREQ / BAUD_RATE cycles
//   FIFO_DEPTH  byte FIFO entries (power of two, >= 2)
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   tx_data_i     byte to transmit
//   tx_valid_i    producer offers tx_data_i (accepted when tx_ready_o is 1)
//   tx_ready_o    FIFO can accept a byte
//   uart_txd      serial line, idle high (registered)
//   busy_o        frame in progress or FIFO non-empty
//   fifo_count_o  bytes queued in the FIFO
module uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          uart_txd,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

`ifdef UART_TX_PARITY_EN
  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic               push_s, pop_s, bit_done_s;

  // ready_q always equals (count_q < FIFO_DEPTH), so a full FIFO refuses a
  // push even when a pop happens on the same edge.
  assign push_s     = tx_valid_i & ready_q;
  assign bit_done_s = (cnt_q == CNT_LAST);

  // Next-state logic: FSM, baud counter, bit index and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        bit_d = 3'd0;
        if (count_q != {(PTR_W + 1){1'b0}}) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_done_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        bit_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Line value for the current state; registered, so the line trails the
  // state by one cycle (push -> pop -> START shows low two cycles after push).
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      S_IDLE:   txd_d = 1'b1;
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = even_parity(shift_q);
`endif
      S_STOP:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO occupancy and the registered status flags derived from it.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d < DEPTH_C);
    // Extra term keeps busy high through the last stop-bit cycle on the line.
    busy_d  = (state_d != S_IDLE) | (count_d != {(PTR_W + 1){1'b0}}) |
              (state_q != S_IDLE);
  end

  // Transmitter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // FIFO pointers, count and status flags; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W + 1){1'b0}};
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      count_q <= count_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= tx_data_i;
    end
  end

  assign uart_txd     = txd_q;
  assign tx_ready_o   = ready_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with DIV = 10. A byte-queue reference model predicts,
// for every cycle, the line level (from frame offset arithmetic), the FIFO
// count, ready and busy. A table of bytes with hand-written frame images is
// also checked at mid-bit, followed by hand sequences for back-to-back
// frames, FIFO full, mid-frame reset, and a randomized run.
module tb_uart_tx;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 10;
  localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int L = NSLOT * DIV;

  logic       clk, rst, tx_valid_i, tx_ready_o, uart_txd, busy_o;
  logic [7:0] tx_data_i;
  logic [2:0] fifo_count_o;

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .uart_txd(uart_txd), .busy_o(busy_o),
    .fifo_count_o(fifo_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  int         n_vec = 0;
  int         n_err = 0;
  int         e     = 0;        // number of rising edges seen
  int         fp    = -100000;  // edge at which the current frame was popped
  logic [7:0] fb    = 8'h00;    // byte of the current frame
  logic [7:0] mq[$];            // bytes queued in the FIFO (model)

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // {stop, d7..d0, start}, bit 0 goes out first
    logic       par;
  } vec_t;
  vec_t tbl[8];

  // Model: state after edge k is "in a frame" while k is within L edges of the pop.
  function automatic bit active(input int k);
    return (k >= fp) && (k < fp + L);
  endfunction

  // Model: line level after edge k reflects the frame slot during edge k-1.
  function automatic logic line_at(input int k);
    int s;
    if (!active(k - 1)) return 1'b1;
    s = (k - 1 - fp) / DIV;
    if (s == 0) return 1'b0;
    if (s <= 8) return fb[s - 1];
    if (NSLOT == 11 && s == 9) return ^fb;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
    end
  endtask

  task automatic check_outputs();
    chk("txd", 32'(uart_txd), 32'(line_at(e)));
    chk("count", 32'(fifo_count_o), 32'(mq.size()));
    chk("ready", 32'(tx_ready_o), 32'(mq.size() < DEPTH));
    if (active(e) || mq.size() != 0) chk("busy_hi", 32'(busy_o), 32'd1);
    else if (!active(e - 1)) chk("busy_lo", 32'(busy_o), 32'd0);
  endtask

  // One clock: drive at negedge, advance model at posedge, check at next negedge.
  task automatic tick(input logic v, input logic [7:0] d, output bit acc);
    tx_valid_i = v;
    tx_data_i  = d;
    acc = v && (mq.size() < DEPTH);
    @(posedge clk);
    e++;
    if (mq.size() != 0 && !active(e - 1)) begin
      fb = mq.pop_front();
      fp = e;
    end
    if (acc) mq.push_back(d);
    @(negedge clk);
    tx_valid_i = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, a);
  endtask

  task automatic drain();
    int g = 0;
    bit a;
    while (g < 3000 && (mq.size() != 0 || active(e) || active(e - 1))) begin
      tick(1'b0, 8'h00, a);
      g++;
    end
    if (g >= 3000) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      check_outputs();
    end
  endtask

  // Assert reset at a negedge and check the outputs respond before any edge.
  task automatic apply_reset();
    rst = 1'b0;
    mq.delete();
    fp = -100000;
    #1;
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    chk("rst_ready", 32'(tx_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check_outputs();
    reset_cycles(3);
    rst = 1'b1;
  endtask

  initial begin
    bit acc;
    int e0, g, s;
    logic [9:0] fr;
    logic expb;
    logic [7:0] five[5];

    tbl[0] = '{8'h55, 10'h2AA, 1'b0};
    tbl[1] = '{8'hA3, 10'h346, 1'b0};
    tbl[2] = '{8'h0F, 10'h21E, 1'b0};
    tbl[3] = '{8'h00, 10'h200, 1'b0};
    tbl[4] = '{8'hFF, 10'h3FE, 1'b0};
    tbl[5] = '{8'h07, 10'h20E, 1'b1};
    tbl[6] = '{8'h03, 10'h206, 1'b0};
    tbl[7] = '{8'h80, 10'h300, 1'b1};

    rst        = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    #2;
    apply_reset();

    // Single frames against hand-written frame images, sampled mid-bit.
    for (int i = 0; i < 8; i++) begin
      drain();
      fr = tbl[i].frame;
      tick(1'b1, tbl[i].data, acc);
      e0 = e;
      for (int c = 1; c <= L + 3; c++) begin
        tick(1'b0, 8'h00, acc);
        if (c == 1) chk("lat_hi", 32'(uart_txd), 32'd1);
        if (c == 2) chk("lat_lo", 32'(uart_txd), 32'd0);
        if (c >= 2 && (c - 2) % DIV == 5 && (c - 2) / DIV < NSLOT) begin
          s = (c - 2) / DIV;
          if (s <= 8) expb = fr[s];
          else if (NSLOT == 11 && s == 9) expb = tbl[i].par;
          else expb = 1'b1;
          chk("frame_bit", 32'(uart_txd), 32'(expb));
        end
      end
    end

    // Back-to-back: exactly one idle-high cycle between stop and next start.
    drain();
    tick(1'b1, 8'hA3, acc);
    tick(1'b1, 8'h0F, acc);
    for (int c = 2; c <= L + 4; c++) begin
      tick(1'b0, 8'h00, acc);
      if (c == L + 2) chk("b2b_gap", 32'(uart_txd), 32'd1);
      if (c == L + 3) chk("b2b_start", 32'(uart_txd), 32'd0);
    end
    drain();

    // Fill the FIFO behind a frame in flight; the fifth byte must wait.
    tick(1'b1, 8'h11, acc);
    idle(3);
    five = '{8'h21, 8'h42, 8'h63, 8'h84, 8'hA5};
    for (int j = 0; j < 5; j++) begin
      g = 0;
      acc = 1'b0;
      while (!acc && g < 200) begin
        tick(1'b1, five[j], acc);
        g++;
      end
      if (!acc) chk("push_timeout", 32'd0, 32'd1);
      if (j == 3) begin
        chk("full_count", 32'(fifo_count_o), 32'd4);
        chk("full_ready", 32'(tx_ready_o), 32'd0);
      end
      if (j == 4) chk("held_off", 32'(g > 1), 32'd1);
    end
    drain();

    // Reset 35 cycles into a frame with more bytes queued behind it.
    tick(1'b1, 8'hC4, acc);
    tick(1'b1, 8'h5A, acc);
    tick(1'b1, 8'h3C, acc);
    g = 0;
    while (e < fp + 35 && g < 200) begin
      tick(1'b0, 8'h00, acc);
      g++;
    end
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    apply_reset();
    idle(20);
    tick(1'b1, 8'h81, acc);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 2) == 0), 8'($urandom), acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, byte FIFO entries, power of two, at least 2.
REQ-004 The block SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port tx_data_i, input, 8, byte to transmit.
REQ-007 The block SHALL have port tx_valid_i, input, 1, producer offers tx_data_i.
REQ-008 The block SHALL have port tx_ready_o, output, 1, FIFO can accept a byte.
REQ-009 The block SHALL have port uart_txd, output, 1, serial line, idle high.
REQ-010 The block SHALL have port busy_o, output, 1, frame in progress or FIFO non-empty.
REQ-011 The block SHALL have port fifo_count_o, output, log2(FIFO_DEPTH)+1, bytes queued.

Function
REQ-012 The block SHALL use bit period DIV = CLK_FREQ/BAUD_RATE, integer-truncated; every line bit SHALL last exactly DIV cycles.
REQ-013 The block SHALL accept a byte on any rising edge where tx_valid_i and tx_ready_o are both 1.
REQ-014 The block SHALL drive tx_ready_o = 1 when fifo_count_o < FIFO_DEPTH; when full, the block SHALL accept no push, even if a pop occurs in the same cycle.
REQ-015 The block SHALL permit a push and a pop in the same cycle when not full, leaving fifo_count_o unchanged.
REQ-016 The block SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH and preserve byte order.
REQ-017 The block SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY, see REQ-029).
REQ-018 IDLE SHALL hold uart_txd = 1; when the FIFO is non-empty, the block SHALL pop the head into a shift register and go to START on the next edge.
REQ-019 START SHALL drive uart_txd = 0 for DIV cycles, then go to DATA.
REQ-020 DATA SHALL send 8 bits LSB first, DIV cycles each, counted by a 3-bit index, then go to STOP.
REQ-021 STOP SHALL drive uart_txd = 1 for DIV cycles; at the end, the block SHALL go to IDLE.
REQ-022 The first-byte latency SHALL be: a byte pushed into an empty FIFO while IDLE drives uart_txd low 2 cycles after the push edge (push edge, then pop edge, then START).
REQ-023 For back-to-back frames, the stop bit and the next start bit SHALL be separated by exactly 1 IDLE cycle.
REQ-024 uart_txd SHALL be registered, with no combinational path from inputs.
REQ-025 busy_o SHALL be 1 whenever the state is not IDLE or fifo_count_o is not 0.

Reset
REQ-026 Asserting rst low SHALL immediately force: state IDLE, uart_txd 1, FIFO empty, fifo_count_o 0, tx_ready_o 1, busy_o 0, baud counter 0, bit index 0.
REQ-027 Reset in mid-frame SHALL abort the frame, discard all queued bytes, and return the line high without glitching low.
REQ-028 After rst deasserts, the block SHALL accept its first push on the next rising edge.

Configuration
REQ-029 With macro UART_TX_PARITY_EN defined, the block SHALL insert a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the 8 data bits) for DIV cycles, giving a frame of 11*DIV cycles.
REQ-030 Without UART_TX_PARITY_EN, the block SHALL omit the PARITY state and logic, giving a frame of 10*DIV cycles.

Verification (CLK_FREQ=1000000, BAUD_RATE=100000, DIV=10)
REQ-031 Push 0x55 when idle -> uart_txd low at cycle +2 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles; busy_o falls after the stop bit.
REQ-032 Push 0xA3, 0x0F back-to-back -> two frames in order, with exactly 1 high cycle between the stop bit and the second start bit.
REQ-033 Push 5 bytes with no pop possible in between -> tx_ready_o = 0 once fifo_count_o = 4, fifth byte held off until the first pop, all 5 bytes transmitted in order.
REQ-034 Assert rst at cycle 35 of a frame -> uart_txd = 1 immediately, fifo_count_o = 0, no further frame; a subsequent push of 0x81 transmits cleanly.
REQ-035 With UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1, frame length 110 cycles; push 0x03 -> parity bit 0.
